// File: rtl/rom_loader.sv
// rom_loader: streams a byte image into the instruction memory over a
// valid/ready handshake, then verifies a trailing two's-complement checksum
// byte. The CPU pipeline is held in reset until a load completes cleanly.
module rom_loader #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              R,
    input  logic              start,
    input  logic [LEN_W-1:0]  length,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [7:0]          sum_q, sum_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_data_q, mem_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                cpu_hold_q, cpu_hold_d;

    logic                xfer;
    logic [LEN_W-1:0]    cnt_inc;
    logic [7:0]          chk_exp;

    assign xfer    = in_valid && in_ready_q;
    assign cnt_inc = cnt_q + LEN_W'(1);
    assign chk_exp = ~sum_q + 8'd1;

    // Next-state, datapath and output decode; outputs are decoded from the
    // next state so the registered versions change on the same edge as state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        sum_d      = sum_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    if ((length[1:0] != 2'b00) || (length > DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = length;
                        cnt_d   = '0;
                        sum_d   = '0;
                        state_d = (length != '0) ? S_LOAD : S_CHECK;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = cnt_q[ADDR_W-1:0];
                    mem_data_d = in_byte;
                    cnt_d      = cnt_inc;
                    sum_d      = sum_q + in_byte;
                    if (cnt_inc == len_q) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    state_d = (in_byte == chk_exp) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
        busy_d     = (state_d == S_LOAD) || (state_d == S_CHECK);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        cpu_hold_d = (state_d != S_DONE);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!R) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            in_ready_q <= in_ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

    assign in_ready = in_ready_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cpu_hold = cpu_hold_q;

endmodule
